inst_rom_loader: RTL

//  Instruction-memory responder for the CPU fetch port: answers rom_ce/rom_addr with rom_data (32-bit words).

---
 rtl/inst_rom_loader_if.sv | 24 ++
 rtl/inst_rom_loader.sv | 77 +++++++
 2 files changed

// File: rtl/inst_rom_loader_if.sv
// inst_rom_loader_if: fetch port and byte-stream loader bundle for inst_rom_loader
//   master: CPU/loader side, drives fetch requests and the byte stream
//   slave : the ROM, returns instructions and loader status
interface inst_rom_loader_if #(parameter int ADDR_WIDTH = 10);
    logic                  ce_i;
    logic [31:0]           addr_i;
    logic [31:0]           inst_o;
    logic                  ld_start_i;
    logic                  ld_end_i;
    logic                  ld_valid_i;
    logic [7:0]            ld_data_i;
    logic                  ld_ready_o;
    logic                  cpu_hold_o;
    logic [ADDR_WIDTH:0]   ld_words_o;
    logic                  ld_ovf_o;
    modport master (
        output ce_i, addr_i, ld_start_i, ld_end_i, ld_valid_i, ld_data_i,
        input  inst_o, ld_ready_o, cpu_hold_o, ld_words_o, ld_ovf_o
    );
    modport slave (
        input  ce_i, addr_i, ld_start_i, ld_end_i, ld_valid_i, ld_data_i,
        output inst_o, ld_ready_o, cpu_hold_o, ld_words_o, ld_ovf_o
    );
endinterface

// File: rtl/inst_rom_loader.sv
// inst_rom_loader: instruction ROM with run-time byte-stream loader (MSB-first words)
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : slave side of inst_rom_loader_if (fetch port + loader stream + status)
module inst_rom_loader #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic              clk,
    input  logic              rst,
    inst_rom_loader_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    typedef enum logic [1:0] {IDLE, LOAD, FLUSH} state_t;
    state_t      state;
    logic [23:0] shift;
    logic [1:0]  byte_cnt;
    logic [31:0] mem [DEPTH];
    logic        full, acc, restart, complete, flush, we;
    logic [1:0]  next_cnt;
    logic [31:0] pad, wdata;
    // ld_words_o saturates at DEPTH, so its top bit alone flags a full array
    assign full     = bus.ld_words_o[ADDR_WIDTH];
    assign acc      = bus.ld_ready_o && bus.ld_valid_i;
    assign restart  = bus.ld_start_i && state != FLUSH;
    assign complete = acc && byte_cnt == 2'd3 && !bus.ld_start_i;
    assign flush    = state == FLUSH;
    assign we       = (complete || flush) && !full;
    assign next_cnt = byte_cnt + 2'(acc);
    // partial word left-justified, missing low bytes read as zero
    assign pad   = byte_cnt == 2'd1 ? {shift[7:0], 24'h0} :
                   byte_cnt == 2'd2 ? {shift[15:0], 16'h0} : {shift, 8'h0};
    assign wdata = flush ? pad : {shift, bus.ld_data_i};
    // the write pointer is the word count itself; writes stop once it reaches DEPTH
    always_ff @(posedge clk)
        if (we) mem[bus.ld_words_o[ADDR_WIDTH-1:0]] <= wdata;
    assign bus.inst_o = (bus.ce_i && !bus.cpu_hold_o) ? mem[bus.addr_i[ADDR_WIDTH+1:2]] : 32'h0;
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            shift          <= '0;
            byte_cnt       <= '0;
            bus.ld_words_o <= '0;
            bus.ld_ovf_o   <= 1'b0;
            bus.ld_ready_o <= 1'b0;
            bus.cpu_hold_o <= 1'b0;
        end else if (restart) begin
            state          <= LOAD;
            shift          <= '0;
            byte_cnt       <= '0;
            bus.ld_words_o <= '0;
            bus.ld_ovf_o   <= 1'b0;
            bus.ld_ready_o <= 1'b1;
            bus.cpu_hold_o <= 1'b1;
        end else if (state == LOAD) begin
            if (acc) begin
                shift    <= {shift[15:0], bus.ld_data_i};
                byte_cnt <= next_cnt;
            end
            if (complete) begin
                bus.ld_words_o <= bus.ld_words_o + {{ADDR_WIDTH{1'b0}}, !full};
                bus.ld_ovf_o   <= bus.ld_ovf_o | full;
            end
            // end is judged after the byte on this edge is counted
            if (bus.ld_end_i) begin
                state          <= next_cnt == 2'd0 ? IDLE : FLUSH;
                bus.ld_ready_o <= 1'b0;
                bus.cpu_hold_o <= next_cnt != 2'd0;
            end
        end else if (flush) begin
            bus.ld_words_o <= bus.ld_words_o + {{ADDR_WIDTH{1'b0}}, !full};
            bus.ld_ovf_o   <= bus.ld_ovf_o | full;
            byte_cnt       <= '0;
            state          <= IDLE;
            bus.cpu_hold_o <= 1'b0;
        end
    end
endmodule
